// File: rtl/player_shot_ctrl.sv
// player_shot_ctrl
// Schedules the player's projectiles from a small pool of shot slots.
// - A shot is allocated on a frame tick when fire is held, the cooldown has
//   expired and a slot is free.
// - In-flight shots climb SHOT_STEP pixels per frame tick.
// - A shot retires when it reaches the top of the screen or receives a hit pulse.
// - shot_active and the shot coordinates are registered. is_shot is a
//   combinational per-pixel query for the colour mapper.
module player_shot_ctrl #(
  parameter int          NUM_SHOTS       = 4,
  parameter logic [9:0]  SHOT_STEP       = 10'd4,
  parameter logic [9:0]  SHOT_LEN        = 10'd4,
  parameter logic [9:0]  SHOT_Y_MIN      = 10'd0,
  parameter logic [9:0]  NOSE_OFFSET     = 10'd3,
  parameter logic [3:0]  COOLDOWN_FRAMES = 4'd15
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic                      fire,
  input  logic [9:0]                player_x_pos,
  input  logic [9:0]                player_y_pos,
  input  logic [NUM_SHOTS-1:0]      hit,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [NUM_SHOTS-1:0]      shot_active,
  output logic [NUM_SHOTS*10-1:0]   shot_x_flat,
  output logic [NUM_SHOTS*10-1:0]   shot_y_flat,
  output logic                      is_shot
);

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_t;

  typedef enum logic {
    FIRE_READY    = 1'b0,
    FIRE_COOLDOWN = 1'b1
  } fire_state_t;

  logic                        frame_q;
  logic                        tick;
  slot_state_t                 slot_state [NUM_SHOTS];
  logic [NUM_SHOTS-1:0][9:0]   shot_x;
  logic [NUM_SHOTS-1:0][9:0]   shot_y;
  fire_state_t                 fire_state;
  logic [3:0]                  cooldown;
  logic [NUM_SHOTS-1:0]        free_onehot;
  logic                        slot_free;
  logic                        spawn_blocked;
  logic                        spawn_ok;
  logic [10:0]                 retire_limit;
  logic [10:0]                 spawn_floor;
  logic [9:0]                  spawn_y;

  // Thresholds are widened to 11 bits so parameter sums cannot wrap.
  assign retire_limit  = {1'b0, SHOT_Y_MIN} + {1'b0, SHOT_STEP};
  assign spawn_floor   = {1'b0, NOSE_OFFSET} + {1'b0, SHOT_Y_MIN};
  assign spawn_blocked = ({1'b0, player_y_pos} < spawn_floor);
  assign spawn_y       = player_y_pos - NOSE_OFFSET;

  // Rising-edge detect of the vertical-sync clock. tick is a one-Clk pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      tick    <= frame_clk & ~frame_q;
    end
  end

  // Pick the lowest-index slot that is idle right now. A slot freed on this
  // same edge is still counted as busy.
  always_comb begin
    free_onehot = '0;
    slot_free   = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!slot_free && (slot_state[i] == SLOT_IDLE)) begin
        free_onehot[i] = 1'b1;
        slot_free      = 1'b1;
      end
    end
  end

  // A shot is launched only on a tick. A request that arrives with the pool
  // full, or with the player too close to the top, is dropped.
  assign spawn_ok = tick & fire & (fire_state == FIRE_READY) & slot_free & ~spawn_blocked;

  // Fire rate limiter: one accepted shot every COOLDOWN_FRAMES+1 ticks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_state <= FIRE_READY;
      cooldown   <= 4'd0;
    end else if (tick) begin
      case (fire_state)
        FIRE_READY: begin
          if (spawn_ok) begin
            cooldown <= COOLDOWN_FRAMES;
            if (COOLDOWN_FRAMES != 4'd0) begin
              fire_state <= FIRE_COOLDOWN;
            end
          end
        end
        FIRE_COOLDOWN: begin
          if (cooldown <= 4'd1) begin
            cooldown   <= 4'd0;
            fire_state <= FIRE_READY;
          end else begin
            cooldown <= cooldown - 4'd1;
          end
        end
        default: begin
          fire_state <= FIRE_READY;
          cooldown   <= 4'd0;
        end
      endcase
    end
  end

  // Per-slot lifecycle. A hit wins over movement. A shot that would step past
  // the top retires instead of wrapping. A fresh shot does not move on its
  // spawn tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        slot_state[i] <= SLOT_IDLE;
        shot_x[i]     <= 10'd0;
        shot_y[i]     <= 10'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (slot_state[i] == SLOT_FLYING) begin
          if (hit[i]) begin
            slot_state[i] <= SLOT_IDLE;
          end else if (tick) begin
            if ({1'b0, shot_y[i]} < retire_limit) begin
              slot_state[i] <= SLOT_IDLE;
            end else begin
              shot_y[i] <= shot_y[i] - SHOT_STEP;
            end
          end
        end else if (spawn_ok && free_onehot[i]) begin
          slot_state[i] <= SLOT_FLYING;
          shot_x[i]     <= player_x_pos;
          shot_y[i]     <= spawn_y;
        end
      end
    end
  end

  // Flatten the slot registers for the collision logic.
  always_comb begin
    for (int i = 0; i < NUM_SHOTS; i++) begin
      shot_active[i] = (slot_state[i] == SLOT_FLYING);
    end
  end

  assign shot_x_flat = shot_x;
  assign shot_y_flat = shot_y;

  // Pixel query: a shot is a one-pixel-wide vertical bar SHOT_LEN tall.
  // The bottom bound is computed in 11 bits so it cannot wrap.
  always_comb begin
    is_shot = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if ((slot_state[i] == SLOT_FLYING) &&
          (DrawX == shot_x[i]) &&
          (DrawY >= shot_y[i]) &&
          ({1'b0, DrawY} <= ({1'b0, shot_y[i]} + {1'b0, SHOT_LEN} - 11'd1))) begin
        is_shot = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_shot_ctrl.sv
// tb_player_shot_ctrl
// Scoreboarded bench for the player shot scheduler (default parameters).
module tb_player_shot_ctrl;

  localparam int NS = 4;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            frame_clk;
  logic            fire;
  logic [9:0]      player_x_pos;
  logic [9:0]      player_y_pos;
  logic [NS-1:0]   hit;
  logic [9:0]      DrawX;
  logic [9:0]      DrawY;
  logic [NS-1:0]   shot_active;
  logic [NS*10-1:0] shot_x_flat;
  logic [NS*10-1:0] shot_y_flat;
  logic            is_shot;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [3:0]  act;
    logic [39:0] xf;
    logic [39:0] yf;
  } expect_t;

  expect_t scoreboard[$];

  logic [3:0]  ea;
  logic [39:0] ex;
  logic [39:0] ey;

  player_shot_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .fire         (fire),
    .player_x_pos (player_x_pos),
    .player_y_pos (player_y_pos),
    .hit          (hit),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .shot_active  (shot_active),
    .shot_x_flat  (shot_x_flat),
    .shot_y_flat  (shot_y_flat),
    .is_shot      (is_shot)
  );

  always #5 Clk = ~Clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [3:0] act, input logic [39:0] xf, input logic [39:0] yf);
    expect_t e;
    e.tag = tag;
    e.act = act;
    e.xf  = xf;
    e.yf  = yf;
    scoreboard.push_back(e);
  endtask

  task automatic compareScoreboard();
    expect_t e;
    checkOutput("sb_depth", 40'(scoreboard.size()), 40'd1);
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput({e.tag, "_act"}, 40'(shot_active), 40'(e.act));
      checkOutput({e.tag, "_x"}, shot_x_flat, e.xf);
      checkOutput({e.tag, "_y"}, shot_y_flat, e.yf);
    end
  endtask

  // One frame: frame_clk rises, the tick is live during the following cycle
  // (where hit is applied), outputs are sampled on the negedge after it acts.
  task automatic applyStimulus(input logic f, input logic [3:0] h);
    @(negedge Clk);
    frame_clk = 1'b1;
    fire      = f;
    @(negedge Clk);
    frame_clk = 1'b0;
    hit       = h;
    @(negedge Clk);
    hit       = 4'd0;
  endtask

  task automatic hitPulse(input logic [3:0] h);
    @(negedge Clk);
    hit = h;
    @(negedge Clk);
    hit = 4'd0;
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    fire      = 1'b0;
    hit       = 4'd0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  function automatic logic [9:0] autoY(input int t, input int k);
    return 10'(447 - 4 * (t - 16 * k));
  endfunction

  function automatic logic [39:0] slot0(input logic [9:0] v);
    logic [39:0] r;
    r = 40'd0;
    r[9:0] = v;
    return r;
  endfunction

  initial begin
    Reset_n      = 1'b0;
    frame_clk    = 1'b0;
    fire         = 1'b0;
    hit          = 4'd0;
    player_x_pos = 10'd320;
    player_y_pos = 10'd450;
    DrawX        = 10'd0;
    DrawY        = 10'd0;
    #1;
    checkOutput("reset_act", 40'(shot_active), 40'd0);
    checkOutput("reset_x", shot_x_flat, 40'd0);
    checkOutput("reset_y", shot_y_flat, 40'd0);
    checkOutput("reset_is_shot", 40'(is_shot), 40'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Single shot from (320,450), then three climbing ticks.
    pushExpect("spawn", 4'b0001, slot0(10'd320), slot0(10'd447));
    applyStimulus(1'b1, 4'd0);
    compareScoreboard();
    for (int t = 1; t <= 3; t++) begin
      pushExpect($sformatf("climb_t%0d", t), 4'b0001, slot0(10'd320), slot0(10'(447 - 4 * t)));
      applyStimulus(1'b0, 4'd0);
      compareScoreboard();
    end

    // Pixel test on the shot at y=435 (rows 435..438).
    DrawX = 10'd320;
    for (int r = 434; r <= 439; r++) begin
      DrawY = 10'(r);
      #1;
      checkOutput($sformatf("is_shot_row%0d", r), 40'(is_shot), 40'((r >= 435) && (r <= 438)));
    end
    DrawX = 10'd321;
    DrawY = 10'd436;
    #1;
    checkOutput("is_shot_wrong_col", 40'(is_shot), 40'd0);

    // Fire held during cooldown: no second shot until tick 16.
    for (int t = 4; t <= 15; t++) begin
      pushExpect($sformatf("cool_t%0d", t), 4'b0001, slot0(10'd320), slot0(10'(447 - 4 * t)));
      applyStimulus(1'b1, 4'd0);
      compareScoreboard();
    end
    ex = slot0(10'd320);
    ex[19:10] = 10'd320;
    ey = slot0(10'd383);
    ey[19:10] = 10'd447;
    pushExpect("second_spawn", 4'b0011, ex, ey);
    applyStimulus(1'b1, 4'd0);
    compareScoreboard();

    // Asynchronous reset with two shots in flight.
    DrawX = 10'd320;
    DrawY = 10'd383;
    #1;
    checkOutput("pre_reset_is_shot", 40'(is_shot), 40'd1);
    Reset_n   = 1'b0;
    fire      = 1'b0;
    #1;
    checkOutput("async_reset_act", 40'(shot_active), 40'd0);
    checkOutput("async_reset_is_shot", 40'(is_shot), 40'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Autofire with fire held: spawns at ticks 0,16,32,48 into slots 0..3,
    // then the pool stays full through tick 66.
    for (int t = 0; t < 67; t++) begin
      ea = 4'd0;
      ex = 40'd0;
      ey = 40'd0;
      for (int k = 0; k < NS; k++) begin
        if (t >= 16 * k) begin
          ea[k]          = 1'b1;
          ex[k*10 +: 10] = 10'd320;
          ey[k*10 +: 10] = autoY(t, k);
        end
      end
      pushExpect($sformatf("auto_t%0d", t), ea, ex, ey);
      applyStimulus(1'b1, 4'd0);
      compareScoreboard();
    end

    // Retire slot 2 between ticks; cooldown was never loaded while full, so
    // the very next tick refills slot 2 at the new player x.
    ea[2] = 1'b0;
    pushExpect("hit_slot2", ea, ex, ey);
    hitPulse(4'b0100);
    compareScoreboard();

    player_x_pos = 10'd100;
    ea = 4'b1111;
    ey[9:0]   = autoY(67, 0);
    ey[19:10] = autoY(67, 1);
    ey[29:20] = 10'd447;
    ey[39:30] = autoY(67, 3);
    ex[29:20] = 10'd100;
    pushExpect("refill_slot2", ea, ex, ey);
    applyStimulus(1'b1, 4'd0);
    compareScoreboard();

    // Hit on the same cycle as a tick: slot 1 retires without moving.
    ea = 4'b1101;
    ey[9:0]   = autoY(68, 0);
    ey[29:20] = 10'd443;
    ey[39:30] = autoY(68, 3);
    pushExpect("hit_on_tick", ea, ex, ey);
    applyStimulus(1'b0, 4'b0010);
    compareScoreboard();

    // A hit on an already idle slot changes nothing.
    pushExpect("hit_idle", ea, ex, ey);
    hitPulse(4'b0010);
    compareScoreboard();

    // Top of screen: y=3 retires instead of wrapping.
    doReset();
    player_x_pos = 10'd320;
    player_y_pos = 10'd6;
    pushExpect("top_spawn3", 4'b0001, slot0(10'd320), slot0(10'd3));
    applyStimulus(1'b1, 4'd0);
    compareScoreboard();
    pushExpect("top_retire3", 4'b0000, slot0(10'd320), slot0(10'd3));
    applyStimulus(1'b0, 4'd0);
    compareScoreboard();

    // y=4 climbs to 0, then retires.
    doReset();
    player_y_pos = 10'd7;
    pushExpect("top_spawn4", 4'b0001, slot0(10'd320), slot0(10'd4));
    applyStimulus(1'b1, 4'd0);
    compareScoreboard();
    pushExpect("top_move0", 4'b0001, slot0(10'd320), slot0(10'd0));
    applyStimulus(1'b0, 4'd0);
    compareScoreboard();
    pushExpect("top_retire0", 4'b0000, slot0(10'd320), slot0(10'd0));
    applyStimulus(1'b0, 4'd0);
    compareScoreboard();

    // Fire pulsed between ticks is ignored.
    doReset();
    player_y_pos = 10'd3;
    @(negedge Clk);
    fire = 1'b1;
    @(negedge Clk);
    fire = 1'b0;
    pushExpect("fire_between", 4'b0000, 40'd0, 40'd0);
    applyStimulus(1'b0, 4'd0);
    compareScoreboard();

    // Spawn guard: too close to the top drops the request without cooldown.
    player_y_pos = 10'd2;
    pushExpect("guard_drop", 4'b0000, 40'd0, 40'd0);
    applyStimulus(1'b1, 4'd0);
    compareScoreboard();
    player_y_pos = 10'd3;
    pushExpect("guard_edge", 4'b0001, slot0(10'd320), slot0(10'd0));
    applyStimulus(1'b1, 4'd0);
    compareScoreboard();

    checkOutput("sb_final", 40'(scoreboard.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
